// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: prefix bytes, handshake FSM states and the
// set-2 scan-code to ASCII table.
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        StIdle,
        StPop,
        StSettle
    } state_e;

    // Each entry is {scan_code, ascii}; codes not listed map to 0.
    localparam int unsigned ASCII_N = 38;
    localparam logic [15:0] ASCII_MAP [ASCII_N] = '{
        16'h1C41, 16'h3242, 16'h2143, 16'h2344, 16'h2445, 16'h2B46, 16'h3447,
        16'h3348, 16'h4349, 16'h3B4A, 16'h424B, 16'h4B4C, 16'h3A4D, 16'h314E,
        16'h444F, 16'h4D50, 16'h1551, 16'h2D52, 16'h1B53, 16'h2C54, 16'h3C55,
        16'h2A56, 16'h1D57, 16'h2258, 16'h3559, 16'h1A5A, 16'h4530, 16'h1631,
        16'h1E32, 16'h2633, 16'h2534, 16'h2E35, 16'h3636, 16'h3D37, 16'h3E38,
        16'h4639, 16'h2920, 16'h5A0D
    };

    function automatic logic [7:0] ps2_ascii(input logic [7:0] code);
        logic [7:0] res;
        res = 8'h00;
        for (int i = 0; i < ASCII_N; i++) begin
            if (ASCII_MAP[i][15:8] == code) res = ASCII_MAP[i][7:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/ps2_key_tracker_if.sv
// FIFO-side bus between the ps2_keyboard receive FIFO (master) and the
// key tracker (slave).
interface ps2_key_tracker_if;

    logic [7:0] fifo_data;
    logic       fifo_ready;
    logic       fifo_overflow;
    logic       fifo_nextdata_n;

    modport master (
        output fifo_data,
        output fifo_ready,
        output fifo_overflow,
        input  fifo_nextdata_n
    );

    modport slave (
        input  fifo_data,
        input  fifo_ready,
        input  fifo_overflow,
        output fifo_nextdata_n
    );

endinterface

// File: rtl/keycode_to_ascii.sv
// Combinational scan-code to ASCII lookup; extended codes have no ASCII.
module keycode_to_ascii
    import ps2_pkg::*;
(
    input  logic [7:0] code,
    input  logic       ext,
    output logic [7:0] ascii
);

    assign ascii = ext ? 8'h00 : ps2_ascii(code);

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 key tracker: pops bytes from the ps2_keyboard FIFO, decodes
// E0/F0 prefixes, tracks the held key, filters typematic repeats, counts
// presses and keeps a make-code history.
// Optional: define PS2_KEY_TRACKER_ASCII_EN to add the key_ascii output.
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int unsigned HIST_DEPTH = 3,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    ps2_key_tracker_if.slave        fifo,
    output logic [7:0]              key_code,
    output logic                    key_ext,
    output logic                    key_down,
    output logic                    key_event,
    output logic                    key_is_break,
    output logic [CNT_W-1:0]        press_count,
    output logic [8*HIST_DEPTH-1:0] hist,
    output logic                    ovf_sticky
`ifdef PS2_KEY_TRACKER_ASCII_EN
    ,
    output logic [7:0]              key_ascii
`endif
);

    state_e state_q, state_d;
    logic [7:0] byte_q, byte_d;
    logic nextdata_n_q, nextdata_n_d;
    logic brk_pend_q, brk_pend_d, ext_pend_q, ext_pend_d;
    // Held key is kept apart from key_code, which also follows breaks of other keys.
    logic [7:0] held_code_q, held_code_d;
    logic held_ext_q, held_ext_d;
    logic [7:0] key_code_q, key_code_d;
    logic key_ext_q, key_ext_d, key_down_q, key_down_d;
    logic key_event_q, key_event_d, key_is_break_q, key_is_break_d;
    logic [CNT_W-1:0] press_count_q, press_count_d;
    logic [8*HIST_DEPTH-1:0] hist_q, hist_d;
    logic ovf_q, ovf_d;
    logic held_match;

    // Handshake FSM: capture in IDLE, pop in POP, let the FIFO settle.
    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        unique case (state_q)
            StIdle: begin
                if (fifo.fifo_ready) begin
                    byte_d  = fifo.fifo_data;
                    state_d = StPop;
                end
            end
            StPop:    state_d = StSettle;
            StSettle: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        // Registered strobe: low exactly while the FSM sits in POP.
        nextdata_n_d = (state_d != StPop);
        ovf_d = ovf_q | fifo.fifo_overflow;
    end

    assign held_match = key_down_q && (byte_q == held_code_q) && (ext_pend_q == held_ext_q);

    // Byte decode, performed once per consumed byte while in POP.
    always_comb begin
        brk_pend_d     = brk_pend_q;
        ext_pend_d     = ext_pend_q;
        held_code_d    = held_code_q;
        held_ext_d     = held_ext_q;
        key_code_d     = key_code_q;
        key_ext_d      = key_ext_q;
        key_down_d     = key_down_q;
        key_event_d    = 1'b0;
        key_is_break_d = key_is_break_q;
        press_count_d  = press_count_q;
        hist_d         = hist_q;
        if (state_q == StPop) begin
            if (byte_q == PS2_BREAK) begin
                brk_pend_d = 1'b1;
            end else if (byte_q == PS2_EXT) begin
                ext_pend_d = 1'b1;
            end else begin
                brk_pend_d = 1'b0;
                ext_pend_d = 1'b0;
                if (brk_pend_q) begin
                    key_code_d     = byte_q;
                    key_ext_d      = ext_pend_q;
                    key_is_break_d = 1'b1;
                    key_event_d    = 1'b1;
                    if (held_match) key_down_d = 1'b0;
                end else if (!held_match) begin
                    key_code_d     = byte_q;
                    key_ext_d      = ext_pend_q;
                    held_code_d    = byte_q;
                    held_ext_d     = ext_pend_q;
                    key_down_d     = 1'b1;
                    key_is_break_d = 1'b0;
                    key_event_d    = 1'b1;
                    press_count_d  = press_count_q + CNT_W'(1);
                    hist_d         = hist_q << 8;
                    hist_d[7:0]    = byte_q;
                end
            end
        end
    end

    // State register for the handshake and all tracked key state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            byte_q         <= '0;
            nextdata_n_q   <= 1'b1;
            brk_pend_q     <= 1'b0;
            ext_pend_q     <= 1'b0;
            held_code_q    <= '0;
            held_ext_q     <= 1'b0;
            key_code_q     <= '0;
            key_ext_q      <= 1'b0;
            key_down_q     <= 1'b0;
            key_event_q    <= 1'b0;
            key_is_break_q <= 1'b0;
            press_count_q  <= '0;
            hist_q         <= '0;
            ovf_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            byte_q         <= byte_d;
            nextdata_n_q   <= nextdata_n_d;
            brk_pend_q     <= brk_pend_d;
            ext_pend_q     <= ext_pend_d;
            held_code_q    <= held_code_d;
            held_ext_q     <= held_ext_d;
            key_code_q     <= key_code_d;
            key_ext_q      <= key_ext_d;
            key_down_q     <= key_down_d;
            key_event_q    <= key_event_d;
            key_is_break_q <= key_is_break_d;
            press_count_q  <= press_count_d;
            hist_q         <= hist_d;
            ovf_q          <= ovf_d;
        end
    end

`ifdef PS2_KEY_TRACKER_ASCII_EN
    logic [7:0] ascii_next, key_ascii_q;

    keycode_to_ascii u_ascii (
        .code  (byte_q),
        .ext   (ext_pend_q),
        .ascii (ascii_next)
    );

    // ASCII follows key_code: it only moves when a make/break event fires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_ascii_q <= '0;
        end else if (key_event_d) begin
            key_ascii_q <= ascii_next;
        end
    end

    assign key_ascii = key_ascii_q;
`endif

    assign fifo.fifo_nextdata_n = nextdata_n_q;
    assign key_code     = key_code_q;
    assign key_ext      = key_ext_q;
    assign key_down     = key_down_q;
    assign key_event    = key_event_q;
    assign key_is_break = key_is_break_q;
    assign press_count  = press_count_q;
    assign hist         = hist_q;
    assign ovf_sticky   = ovf_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Self-checking bench for ps2_key_tracker: a queue-based FIFO model feeds the
// DUT, and a key-level reference model predicts every event and the final state.
module tb_ps2_key_tracker;

    localparam int unsigned HIST_DEPTH = 3;
    localparam int unsigned CNT_W      = 8;

    logic                    clk;
    logic                    rst;
    logic [7:0]              key_code;
    logic                    key_ext;
    logic                    key_down;
    logic                    key_event;
    logic                    key_is_break;
    logic [CNT_W-1:0]        press_count;
    logic [8*HIST_DEPTH-1:0] hist;
    logic                    ovf_sticky;

    ps2_key_tracker_if fifo_bus ();

    ps2_key_tracker #(
        .HIST_DEPTH (HIST_DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo         (fifo_bus),
        .key_code     (key_code),
        .key_ext      (key_ext),
        .key_down     (key_down),
        .key_event    (key_event),
        .key_is_break (key_is_break),
        .press_count  (press_count),
        .hist         (hist),
        .ovf_sticky   (ovf_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // FIFO contents and monitor bookkeeping.
    logic [7:0] q[$];
    int cyc = 0;
    int last_pop = -100;
    int pops = 0;
    int events_seen = 0;
    bit chk_pending = 0;

    // Reference model: key-level view of the scan-code stream.
    bit         m_brk, m_ext, m_down, m_hext;
    logic [7:0] m_hcode;
    logic [CNT_W-1:0] m_count;
    logic [7:0] m_hist[$];
    bit         e_valid;
    logic [7:0] e_code;
    bit         e_ext, e_brk;

    function automatic void m_reset();
        m_brk = 0; m_ext = 0; m_down = 0; m_hext = 0; m_hcode = 8'h00;
        m_count = '0;
        m_hist.delete();
    endfunction

    function automatic logic [8*HIST_DEPTH-1:0] m_hist_packed();
        logic [8*HIST_DEPTH-1:0] r;
        r = '0;
        for (int i = 0; i < int'(HIST_DEPTH); i++)
            if (i < m_hist.size()) r[8*i +: 8] = m_hist[i];
        return r;
    endfunction

    function automatic void m_byte(input logic [7:0] b);
        e_valid = 0;
        if (b == 8'hF0) m_brk = 1;
        else if (b == 8'hE0) m_ext = 1;
        else begin
            if (m_brk) begin
                e_valid = 1; e_code = b; e_ext = m_ext; e_brk = 1;
                if (m_down && b == m_hcode && m_ext == m_hext) m_down = 0;
            end else if (!(m_down && b == m_hcode && m_ext == m_hext)) begin
                e_valid = 1; e_code = b; e_ext = m_ext; e_brk = 0;
                m_down = 1; m_hcode = b; m_hext = m_ext;
                m_count = m_count + 1'b1;
                m_hist.push_front(b);
                if (m_hist.size() > HIST_DEPTH) void'(m_hist.pop_back());
            end
            m_brk = 0; m_ext = 0;
        end
    endfunction

    // FIFO model and event monitor, evaluated mid-cycle away from the clock edge.
    always @(negedge clk) begin
        if (rst) begin
            chk_pending = 0;
            last_pop = -100;
        end else begin
            if (chk_pending) begin
                chk_pending = 0;
                checks++;
                if (key_event !== e_valid) begin
                    errors++;
                    $display("FAIL event_pulse: key_event=%b required %b", key_event, e_valid);
                end else if (e_valid) begin
                    checks++;
                    if ({key_code, key_ext, key_is_break, key_down, press_count, hist} !==
                        {e_code, e_ext, e_brk, m_down, m_count, m_hist_packed()}) begin
                        errors++;
                        $display("FAIL event_fields: code=%h ext=%b brk=%b down=%b cnt=%0d hist=%h required code=%h ext=%b brk=%b down=%b cnt=%0d hist=%h",
                                 key_code, key_ext, key_is_break, key_down, press_count, hist,
                                 e_code, e_ext, e_brk, m_down, m_count, m_hist_packed());
                    end
                end
            end else if (key_event !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL stray_event: key_event=%b required 0", key_event);
            end
            if (key_event === 1'b1) events_seen++;
            if (fifo_bus.fifo_nextdata_n === 1'b0) begin
                checks++;
                if (cyc - last_pop < 3 || q.size() == 0) begin
                    errors++;
                    $display("FAIL pop_spacing: gap=%0d queued=%0d required gap>=3 queued>=1",
                             cyc - last_pop, q.size());
                end
                last_pop = cyc;
                pops++;
                if (q.size() != 0) begin
                    m_byte(q.pop_front());
                    chk_pending = 1;
                end
                fifo_bus.fifo_ready = (q.size() != 0);
                fifo_bus.fifo_data  = (q.size() != 0) ? q[0] : 8'h00;
            end
        end
        cyc++;
    end

    task automatic push(input logic [7:0] b);
        q.push_back(b);
        fifo_bus.fifo_ready = 1'b1;
        fifo_bus.fifo_data  = q[0];
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        fifo_bus.fifo_ready = 1'b0;
        fifo_bus.fifo_data  = 8'h00;
        m_reset();
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_idle();
        int idle = 0;
        bit done = 0;
        for (int i = 0; i < 5000 && !done; i++) begin
            @(negedge clk);
            #1;
            idle = (q.size() == 0) ? idle + 1 : 0;
            if (idle >= 5) done = 1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain_timeout: queued=%0d required 0", q.size());
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        #1 push(b);
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({key_code, key_ext, key_down, key_event, key_is_break, press_count, hist, ovf_sticky} !== '0
            || fifo_bus.fifo_nextdata_n !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: outs=%h nextdata_n=%b required 0 and 1",
                     {key_code, key_ext, key_down, key_event, key_is_break, press_count, hist, ovf_sticky},
                     fifo_bus.fifo_nextdata_n);
        end
    endtask

    task automatic test_make_break();
        int ev0;
        do_reset();
        ev0 = events_seen;
        send(8'h1C);
        wait_idle();
        checks++;
        if ({key_code, key_down, press_count, hist[7:0]} !== {8'h1C, 1'b1, 8'd1, 8'h1C}) begin
            errors++;
            $display("FAIL make_1c: code=%h down=%b cnt=%0d h0=%h required 1c 1 1 1c",
                     key_code, key_down, press_count, hist[7:0]);
        end
        send(8'hF0); send(8'h1C);
        wait_idle();
        checks++;
        if ({key_is_break, key_down, press_count, events_seen - ev0} !== {1'b1, 1'b0, 8'd1, 32'd2}) begin
            errors++;
            $display("FAIL break_1c: brk=%b down=%b cnt=%0d ev=%0d required 1 0 1 2",
                     key_is_break, key_down, press_count, events_seen - ev0);
        end
    endtask

    task automatic test_extended();
        int ev0;
        do_reset();
        ev0 = events_seen;
        send(8'hE0); send(8'h75);
        wait_idle();
        checks++;
        if ({key_code, key_ext, key_down} !== {8'h75, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL ext_make: code=%h ext=%b down=%b required 75 1 1", key_code, key_ext, key_down);
        end
        send(8'hE0); send(8'hF0); send(8'h75);
        wait_idle();
        checks++;
        if ({key_ext, key_down, key_is_break, events_seen - ev0} !== {1'b1, 1'b0, 1'b1, 32'd2}) begin
            errors++;
            $display("FAIL ext_break: ext=%b down=%b brk=%b ev=%0d required 1 0 1 2",
                     key_ext, key_down, key_is_break, events_seen - ev0);
        end
    endtask

    task automatic test_typematic();
        int ev0;
        do_reset();
        ev0 = events_seen;
        send(8'h1C); send(8'h1C); send(8'h1C); send(8'h32);
        wait_idle();
        checks++;
        if ({press_count, hist[15:0], events_seen - ev0} !== {8'd2, 16'h1C32, 32'd2}) begin
            errors++;
            $display("FAIL typematic: cnt=%0d h=%h ev=%0d required 2 1c32 2",
                     press_count, hist[15:0], events_seen - ev0);
        end
    endtask

    task automatic test_back_to_back();
        int p0, ev0;
        do_reset();
        p0 = pops; ev0 = events_seen;
        @(negedge clk);
        #1;
        push(8'h21); push(8'hF0); push(8'h21); push(8'h32);
        wait_idle();
        checks++;
        if ({pops - p0, events_seen - ev0, key_code} !== {32'd4, 32'd3, 8'h32}) begin
            errors++;
            $display("FAIL back_to_back: pops=%0d ev=%0d code=%h required 4 3 32",
                     pops - p0, events_seen - ev0, key_code);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 255; i++) send((i % 2 == 0) ? 8'h1C : 8'h32);
        wait_idle();
        checks++;
        if (press_count !== 8'd255) begin
            errors++;
            $display("FAIL count_255: cnt=%0d required 255", press_count);
        end
        send(8'h32);
        wait_idle();
        checks++;
        if (press_count !== 8'd0) begin
            errors++;
            $display("FAIL count_wrap: cnt=%0d required 0", press_count);
        end
    endtask

    task automatic test_reset_mid();
        bit hit = 0;
        do_reset();
        send(8'h1C); send(8'hF0);
        wait_idle();
        #1 push(8'h1C);
        for (int i = 0; i < 50 && !hit; i++) begin
            @(posedge clk);
            #1;
            if (fifo_bus.fifo_nextdata_n === 1'b0) hit = 1;
        end
        if (hit) begin
            rst = 1'b1;
            m_reset();
        end
        #1;
        checks++;
        if (!hit || {key_code, key_ext, key_down, key_event, key_is_break, press_count, hist} !== '0
            || fifo_bus.fifo_nextdata_n !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_pop: hit=%b code=%h down=%b cnt=%0d nextdata_n=%b required 1 00 0 0 1",
                     hit, key_code, key_down, press_count, fifo_bus.fifo_nextdata_n);
        end
        @(negedge clk);
        #1 rst = 1'b0;
        wait_idle();
        checks++;
        if ({key_code, key_is_break, key_down, press_count} !== {8'h1C, 1'b0, 1'b1, 8'd1}) begin
            errors++;
            $display("FAIL after_reset_make: code=%h brk=%b down=%b cnt=%0d required 1c 0 1 1",
                     key_code, key_is_break, key_down, press_count);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        @(negedge clk);
        fifo_bus.fifo_overflow = 1'b1;
        @(negedge clk);
        fifo_bus.fifo_overflow = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (ovf_sticky !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: ovf_sticky=%b required 1", ovf_sticky);
        end
        do_reset();
        checks++;
        if (ovf_sticky !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: ovf_sticky=%b required 0", ovf_sticky);
        end
    endtask

    task automatic test_random();
        logic [7:0] pool [6];
        pool[0] = 8'h1C; pool[1] = 8'h32; pool[2] = 8'h75;
        pool[3] = 8'hE0; pool[4] = 8'hF0; pool[5] = 8'h21;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            send(pool[$urandom_range(0, 5)]);
        end
        wait_idle();
        checks++;
        if ({key_down, press_count, hist} !== {m_down, m_count, m_hist_packed()}) begin
            errors++;
            $display("FAIL random_final: down=%b cnt=%0d hist=%h required %b %0d %h",
                     key_down, press_count, hist, m_down, m_count, m_hist_packed());
        end
    endtask

    initial begin
        rst = 1'b1;
        fifo_bus.fifo_data     = 8'h00;
        fifo_bus.fifo_ready    = 1'b0;
        fifo_bus.fifo_overflow = 1'b0;
        m_reset();
        test_reset();
        test_make_break();
        test_extended();
        test_typematic();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        test_overflow();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
